// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle ops plus iterative shift-add multiply
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND = 4'b0010,
                           OP_OR   = 4'b0011, OP_XOR  = 4'b0100, OP_SLT = 4'b0101,
                           OP_SLL  = 4'b0110, OP_SRL  = 4'b0111, OP_SRA = 4'b1000,
                           OP_MUL  = 4'b1001, OP_SLTU = 4'b1010;

    state_t             state_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   result_q, mcand_q, mplier_q, acc_q, acc_d;
    logic               z_q, n_q, v_q, c_q;

    logic               is_sub, cout, ovf, v_d, c_d;
    logic [WIDTH-1:0]   b_op, sum, res_d;
    logic [SHW-1:0]     shamt;

    // SLT/SLTU reuse the subtractor, so anything other than ADD selects subtract
    always_comb begin
        is_sub       = (ALUControl != OP_ADD);
        b_op         = is_sub ? ~B : B;
        {cout, sum}  = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
        ovf          = ~(A[WIDTH-1] ^ B[WIDTH-1] ^ is_sub) & (A[WIDTH-1] ^ sum[WIDTH-1]);
        shamt        = B[SHW-1:0];
        v_d          = 1'b0;
        c_d          = 1'b0;
        res_d        = '0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                res_d = sum;
                v_d   = ovf;
                c_d   = cout;
            end
            OP_AND:  res_d = A & B;
            OP_OR:   res_d = A | B;
            OP_XOR:  res_d = A ^ B;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OP_SLL:  res_d = A << shamt;
            OP_SRL:  res_d = A >> shamt;
            OP_SRA:  res_d = $unsigned($signed(A) >>> shamt);
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, ~cout};
            default: res_d = '0;
        endcase
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b1;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    if (ALUControl == OP_MUL) begin
                        mcand_q  <= A;
                        mplier_q <= B;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end else begin
                        result_q <= res_d;
                        z_q      <= (res_d == '0);
                        n_q      <= res_d[WIDTH-1];
                        v_q      <= v_d;
                        c_q      <= c_d;
                        state_q  <= DONE;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH-1)) begin
                        result_q <= acc_d;
                        z_q      <= (acc_d == '0);
                        n_q      <= acc_d[WIDTH-1];
                        v_q      <= 1'b0;
                        c_q      <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Result    = result_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign V         = v_q;
    assign C         = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq at WIDTH=32
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  ALUControl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Result;
    logic        Z, N, V, C, busy;

    typedef struct {
        logic [31:0] res;
        logic        z, n, v, c;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .Z(Z), .N(N), .V(V), .C(C),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] wide;
        e.v = 1'b0; e.c = 1'b0; e.lat = 1;
        case (op)
            4'd0: begin
                wide  = {32'd0, a} + {32'd0, b};
                e.res = wide[31:0];
                e.c   = wide[32];
                e.v   = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            4'd1: begin
                e.res = a - b;
                e.c   = (a >= b);
                e.v   = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  e.res = a << b[4:0];
            4'd7:  e.res = a >> b[4:0];
            4'd8:  e.res = $unsigned($signed(a) >>> b[4:0]);
            4'd9: begin
                wide  = {32'd0, a} * {32'd0, b};
                e.res = wide[31:0];
                e.lat = 33;
            end
            4'd10: e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid   = 1'b1;
        A          = a;
        B          = b;
        ALUControl = op;
        sb.push_back(model(op, a, b));
    endtask

    // Counts edges from the accept edge until out_valid, then scores the result.
    task automatic wait_check(input string tag);
        int   lat;
        bit   ready_low;
        exp_t e;
        lat = 0;
        ready_low = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            in_valid = 1'b0;
            if (!out_valid && in_ready) ready_low = 1'b0;
        end while (!out_valid && lat < 100);
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, lat, e.lat);
            chk({tag, "_result"}, Result, e.res);
            chk({tag, "_flags_znvc"}, {Z, N, V, C}, {e.z, e.n, e.v, e.c});
            if (e.lat > 1) chk({tag, "_in_ready_low"}, ready_low, 1'b1);
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_back_to_idle"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    logic [31:0] held_res;
    logic [3:0]  held_flags;
    logic [3:0]  rops[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10};

    initial begin
        // asynchronous reset: state must be forced before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_ctrl", {in_ready, out_valid, busy}, 3'b100);
        chk("rst_result", Result, 32'd0);
        chk("rst_flags", {Z, N, V, C}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;

        issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001); wait_check("add_ovf"); drain("add_ovf");
        issue(4'd1, 32'd5, 32'd5);                 wait_check("sub_zero"); drain("sub_zero");
        issue(4'd1, 32'd0, 32'd1);                 wait_check("sub_borrow"); drain("sub_borrow");
        issue(4'd9, 32'hFFFF_FFFF, 32'd3);         wait_check("mul_m1x3"); drain("mul_m1x3");
        issue(4'd8, 32'h8000_0000, 32'd4);         wait_check("sra4"); drain("sra4");
        issue(4'd8, 32'h8000_0001, 32'd0);         wait_check("sra0"); drain("sra0");
        issue(4'd5, 32'hFFFF_FFFF, 32'd1);         wait_check("slt"); drain("slt");
        issue(4'd10, 32'hFFFF_FFFF, 32'd1);        wait_check("sltu"); drain("sltu");
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0); wait_check("illegal"); drain("illegal");

        // DONE must hold its result while the consumer stalls and new requests arrive
        issue(4'd0, 32'h1111_1111, 32'h2222_2222); wait_check("hold_add");
        held_res   = Result;
        held_flags = {Z, N, V, C};
        @(negedge clk);
        in_valid = 1'b1; A = 32'hDEAD_BEEF; B = 32'h0000_0007; ALUControl = 4'd1;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_result", Result, held_res);
        chk("hold_flags", {Z, N, V, C}, held_flags);
        chk("hold_ctrl", {in_ready, out_valid}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        drain("hold");

        // reset at multiplier iteration 10 discards the operation
        issue(4'd9, 32'h0001_2345, 32'h0000_0777);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midmul_rst_ctrl", {in_ready, out_valid, busy}, 3'b100);
        chk("midmul_rst_result", {Result, Z}, {32'd0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("midmul_no_pulse", {in_ready, out_valid}, 2'b10);
        issue(4'd0, 32'd2, 32'd3); wait_check("post_rst_add"); drain("post_rst_add");

        for (int i = 0; i < 10; i++) begin
            issue(rops[i], $urandom, $urandom_range(0, 31) | (i[0] ? 32'h0 : $urandom));
            wait_check($sformatf("rand_op%0d", rops[i]));
            drain("rand");
        end
        issue(4'd9, $urandom, $urandom); wait_check("rand_mul"); drain("rand_mul");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
